// File: rtl/alu_pkg.sv
// Shared ALU control codes and datapath widths for the decoder and the execute stage.
package alu_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned REG_BITS   = 5;
  localparam int unsigned SHAMT_BITS = 5;

  localparam logic [4:0] AluAnd = 5'b00000;
  localparam logic [4:0] AluOr  = 5'b00001;
  localparam logic [4:0] AluAdd = 5'b00010;
  localparam logic [4:0] AluSub = 5'b00110;
  localparam logic [4:0] AluSlt = 5'b00111;
  localparam logic [4:0] AluXor = 5'b01101;
  localparam logic [4:0] AluSll = 5'b10000;
  localparam logic [4:0] AluSrl = 5'b11000;
  localparam logic [4:0] AluSra = 5'b11001;
  localparam logic [4:0] AluMov = 5'b11010;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result and signed ADD/SUB overflow for one operation.
module alu_core
  import alu_pkg::*;
(
  input  logic [4:0]            ctl_i,
  input  logic                  sign_i,
  input  logic [WIDTH-1:0]      a_i,
  input  logic [WIDTH-1:0]      b_i,
  input  logic [SHAMT_BITS-1:0] shamt_i,
  output logic [WIDTH-1:0]      result_o,
  output logic                  overflow_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
  assign lt      = sign_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

  always_comb begin
    result_o   = sum;
    overflow_o = 1'b0;
    case (ctl_i)
      AluAnd: result_o = a_i & b_i;
      AluOr:  result_o = a_i | b_i;
      AluXor: result_o = a_i ^ b_i;
      AluSub: begin
        result_o   = diff;
        overflow_o = sign_i & sub_ovf;
      end
      AluSlt: result_o = {{(WIDTH-1){1'b0}}, lt};
      AluSll: result_o = b_i << shamt_i;
      AluSrl: result_o = b_i >> shamt_i;
      AluSra: result_o = $unsigned($signed(b_i) >>> shamt_i);
      AluMov: result_o = a_i;
      // AluAdd and every unassigned code behave as ADD.
      default: begin
        result_o   = sum;
        overflow_o = sign_i & add_ovf;
      end
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU plus EX/MEM output register with valid/ready handshake and flush.
module ex_alu_stage #(
  parameter int unsigned WIDTH    = alu_pkg::WIDTH,
  parameter int unsigned REG_BITS = alu_pkg::REG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          ALUCtl,
  input  logic                Sign,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [4:0]          in_shamt,
  input  logic [REG_BITS-1:0] in_wr_reg,
  input  logic                in_reg_write,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic                out_zero,
  output logic                out_overflow,
  output logic [REG_BITS-1:0] out_wr_reg,
  output logic                out_reg_write
);

  import alu_pkg::*;

  logic [WIDTH-1:0]    alu_result;
  logic                alu_ovf;
  logic                accept;
  logic                rw_gated;

  logic                valid_q,     valid_d;
  logic [WIDTH-1:0]    result_q,    result_d;
  logic                zero_q,      zero_d;
  logic                ovf_q,       ovf_d;
  logic [REG_BITS-1:0] wr_reg_q,    wr_reg_d;
  logic                reg_write_q, reg_write_d;

  alu_core u_alu_core (
    .ctl_i      (ALUCtl),
    .sign_i     (Sign),
    .a_i        (in_a),
    .b_i        (in_b),
    .shamt_i    (in_shamt),
    .result_o   (alu_result),
    .overflow_o (alu_ovf)
  );

  // Flush always drains, so the upstream stage can dump its op during a kill.
  assign in_ready = ~valid_q | out_ready | flush;
  assign accept   = in_valid & in_ready;
  assign rw_gated = in_reg_write & ~alu_ovf & ~((ALUCtl == AluMov) && (in_b == '0))
                    & (in_wr_reg != '0);

  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    wr_reg_d    = wr_reg_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      result_d    = alu_result;
      zero_d      = (alu_result == '0);
      ovf_d       = alu_ovf;
      wr_reg_d    = in_wr_reg;
      reg_write_d = rw_gated;
    end else if (out_ready) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      wr_reg_q    <= '0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      wr_reg_q    <= wr_reg_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_result    = result_q;
  assign out_zero      = zero_q;
  assign out_overflow  = ovf_q;
  assign out_wr_reg    = wr_reg_q;
  assign out_reg_write = reg_write_q;

endmodule
